// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: button conditioning plus the
// IDLE/RUN/PAUSE/LAP mode machine that commands the stopwatch core.

module stopwatch_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic evt_o
);

    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic          db_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Accept the synchronized level once it has disagreed for the full window
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state and edge-detect delay
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    assign evt_o = db_q & ~db_dly_q;

endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    output logic       sw_start,
    output logic       sw_stop,
    output logic       sw_clear,
    output logic [5:0] disp_sec,
    output logic [5:0] disp_min,
    output logic [1:0] state,
    output logic       lap_active
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    logic       ss_evt;
    logic       lr_evt;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       start_q;
    logic       start_d;
    logic       stop_q;
    logic       stop_d;
    logic       clear_q;
    logic       clear_d;
    logic       lap_load;
    logic [5:0] lap_sec_q;
    logic [5:0] lap_min_q;
    logic [5:0] disp_sec_q;
    logic [5:0] disp_sec_d;
    logic [5:0] disp_min_q;
    logic [5:0] disp_min_d;

    stopwatch_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_ss (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn_ss),
        .evt_o (ss_evt)
    );

    stopwatch_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_lr (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn_lr),
        .evt_o (lr_evt)
    );

    // Mode transitions; start/stop outranks lap/reset in a tie
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        stop_d   = 1'b0;
        clear_d  = 1'b0;
        lap_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ss_evt) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                end else if (lr_evt) begin
                    clear_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (ss_evt) begin
                    state_d = ST_PAUSE;
                    stop_d  = 1'b1;
                end else if (lr_evt) begin
                    state_d  = ST_LAP;
                    lap_load = 1'b1;
                end
            end
            ST_LAP: begin
                if (ss_evt) begin
                    state_d = ST_PAUSE;
                    stop_d  = 1'b1;
                end else if (lr_evt) begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (ss_evt) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                end else if (lr_evt) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Display shows the frozen lap time while in LAP, else the live count
    always_comb begin
        disp_sec_d = sec_in;
        disp_min_d = min_in;
        if (state_q == ST_LAP) begin
            disp_sec_d = lap_sec_q;
            disp_min_d = lap_min_q;
        end
    end

    // Mode, command pulses, lap capture and display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            clear_q    <= 1'b0;
            lap_sec_q  <= '0;
            lap_min_q  <= '0;
            disp_sec_q <= '0;
            disp_min_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            clear_q    <= clear_d;
            disp_sec_q <= disp_sec_d;
            disp_min_q <= disp_min_d;
            if (lap_load) begin
                lap_sec_q <= sec_in;
                lap_min_q <= min_in;
            end
        end
    end

    assign sw_start   = start_q;
    assign sw_stop    = stop_q;
    assign sw_clear   = clear_q;
    assign disp_sec   = disp_sec_q;
    assign disp_min   = disp_min_q;
    assign state      = state_q;
    assign lap_active = (state_q == ST_LAP);

endmodule
